// File: rtl/i2s_playback_fifo.sv
// Purpose: stereo sample FIFO feeding the I2S transmitter, one L/R pair per frame.
// Latency: a push is counted in level the next cycle; tx_data_* update 2 mclk after the ws fall.
// Backpressure: s_ready drops when DEPTH pairs are stored or during flush; no path from s_valid to s_ready.
//
// Ports:
//   mclk, rst_n             main clock, asynchronous active-low reset
//   s_valid/s_ready         mixer handshake; s_data_l/s_data_r carry the pair
//   ws                      transmitter word-select (high = left half)
//   flush                   synchronous clear of pointers and level
//   tx_data_l/tx_data_r     pair presented to the transmitter for the current frame
//   level                   pairs stored (0..DEPTH)
//   underrun                one-cycle pulse when a frame advance finds nothing to play
//   underrun_cnt            saturating underrun counter, present only when
//                           PLAYBACK_UNDERRUN_CNT_EN is defined
module i2s_playback_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       mclk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data_l,
    input  logic [WIDTH-1:0]           s_data_r,
    input  logic                       ws,
    input  logic                       flush,
    output logic [WIDTH-1:0]           tx_data_l,
    output logic [WIDTH-1:0]           tx_data_r,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       underrun
`ifdef PLAYBACK_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                underrun_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_l [DEPTH];
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             ws_q;
    logic             adv;

    logic push;
    logic pop;
    logic undr;

    // s_ready depends only on registered level and the flush strobe.
    assign s_ready = (level != LW'(DEPTH)) && !flush;
    assign push    = s_valid && s_ready;
    // Flush wins over a coincident advance, which then plays silence.
    assign pop     = adv && (level != '0) && !flush;
    assign undr    = adv && ((level == '0) || flush);

    // Sample storage carries no reset; level/pointers define what is valid.
    always_ff @(posedge mclk) begin
        if (push) begin
            mem_l[wr_ptr] <= s_data_l;
            mem_r[wr_ptr] <= s_data_r;
        end
    end

    // ws_q resets low so a ws held high out of reset cannot fake a falling edge.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            ws_q <= 1'b0;
            adv  <= 1'b0;
        end else begin
            ws_q <= ws;
            adv  <= ws_q && !ws;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // A push landing on an underrun advance still counts: pop is low then.
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // Outputs change only on an advance, just after the transmitter has
    // re-latched, so it never sees a half-updated pair.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_l <= '0;
            tx_data_r <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= undr;
            if (pop) begin
                tx_data_l <= mem_l[rd_ptr];
                tx_data_r <= mem_r[rd_ptr];
            end else if (undr) begin
                tx_data_l <= '0;
                tx_data_r <= '0;
            end
        end
    end

`ifdef PLAYBACK_UNDERRUN_CNT_EN
    // Saturating; only reset clears it so flushes do not hide past underruns.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (undr && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_playback_fifo.sv
// Purpose: directed self-checking bench for i2s_playback_fifo.
// Latency: checks the 2-mclk ws-fall-to-output delay and next-cycle level update.
// Backpressure: exercises full, flush and simultaneous push/pop.
module tb_i2s_playback_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic                   mclk = 1'b0;
    logic                   rst_n;
    logic                   s_valid;
    logic                   s_ready;
    logic [WIDTH-1:0]       s_data_l;
    logic [WIDTH-1:0]       s_data_r;
    logic                   ws;
    logic                   flush;
    logic [WIDTH-1:0]       tx_data_l;
    logic [WIDTH-1:0]       tx_data_r;
    logic [$clog2(DEPTH):0] level;
    logic                   underrun;
`ifdef PLAYBACK_UNDERRUN_CNT_EN
    logic [15:0]            underrun_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    i2s_playback_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .mclk        (mclk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data_l    (s_data_l),
        .s_data_r    (s_data_r),
        .ws          (ws),
        .flush       (flush),
        .tx_data_l   (tx_data_l),
        .tx_data_r   (tx_data_r),
        .level       (level),
        .underrun    (underrun)
`ifdef PLAYBACK_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 mclk = ~mclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Drive a ws fall and stop at the cycle where adv is high (edge E+1);
    // one more tick lands on E+2, where tx_data_* update.
    task automatic fall_to_adv();
        ws = 1'b1;
        tick();
        tick();
        ws = 1'b0;  // falls right after edge E
        tick();     // E+1
    endtask

    task automatic push_pair(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        s_valid  = 1'b1;
        s_data_l = l;
        s_data_r = r;
        tick();
        s_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data_l = '0;
        s_data_r = '0;
        ws       = 1'b0;
        flush    = 1'b0;

        // 1. Reset out, ws toggling during reset.
        for (int i = 0; i < 5; i++) begin
            ws = ~ws;
            tick();
        end
        ws = 1'b0;
        check_eq("rst_s_ready", 32'(s_ready), 32'd1);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        check_eq("rst_tx_l", 32'(tx_data_l), 32'd0);
        check_eq("rst_tx_r", 32'(tx_data_r), 32'd0);
`ifdef PLAYBACK_UNDERRUN_CNT_EN
        check_eq("rst_ucnt", 32'(underrun_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            fall_to_adv();
            check_eq("t1_no_pulse_early", 32'(underrun), 32'd0);
            tick();
            check_eq("t1_underrun", 32'(underrun), 32'd1);
            check_eq("t1_tx_l", 32'(tx_data_l), 32'd0);
            check_eq("t1_tx_r", 32'(tx_data_r), 32'd0);
`ifdef PLAYBACK_UNDERRUN_CNT_EN
            check_eq("t1_ucnt", 32'(underrun_cnt), 32'(f + 1));
`endif
            tick();
            check_eq("t1_pulse_len", 32'(underrun), 32'd0);
        end

        // 2. Fill to full, no ws activity.
        for (int i = 0; i < 16; i++) begin
            check_eq("t2_ready_before", 32'(s_ready), 32'd1);
            push_pair(16'(16'h1000 + i), 16'(16'h2000 + i));
            check_eq("t2_level", 32'(level), 32'(i + 1));
        end
        check_eq("t2_full_ready", 32'(s_ready), 32'd0);
        push_pair(16'hDEAD, 16'hBEEF);
        check_eq("t2_17th_ignored", 32'(level), 32'd16);

        // 3. Ordering: drain over 16 frames, then underrun.
        for (int i = 0; i < 16; i++) begin
            fall_to_adv();
            check_eq("t3_tx_hold_e1", 32'(tx_data_l), (i == 0) ? 32'd0 : 32'(16'h1000 + i - 1));
            tick();
            check_eq("t3_tx_l", 32'(tx_data_l), 32'(16'h1000 + i));
            check_eq("t3_tx_r", 32'(tx_data_r), 32'(16'h2000 + i));
            check_eq("t3_no_underrun", 32'(underrun), 32'd0);
            check_eq("t3_level", 32'(level), 32'(15 - i));
        end
        fall_to_adv();
        tick();
        check_eq("t3_17_tx_l", 32'(tx_data_l), 32'd0);
        check_eq("t3_17_underrun", 32'(underrun), 32'd1);

        // 4. Simultaneous push and pop at level 1.
        push_pair(16'h3001, 16'h4001);
        check_eq("t4_level1", 32'(level), 32'd1);
        fall_to_adv();
        s_valid  = 1'b1;
        s_data_l = 16'h3002;
        s_data_r = 16'h4002;
        tick();
        s_valid  = 1'b0;
        check_eq("t4_level_same", 32'(level), 32'd1);
        check_eq("t4_pop_old_l", 32'(tx_data_l), 32'h3001);
        check_eq("t4_pop_old_r", 32'(tx_data_r), 32'h4001);
        fall_to_adv();
        tick();
        check_eq("t4_next_l", 32'(tx_data_l), 32'h3002);
        check_eq("t4_next_r", 32'(tx_data_r), 32'h4002);
        check_eq("t4_level0", 32'(level), 32'd0);

        // 5. Flush on the adv cycle at level 8.
        for (int i = 0; i < 8; i++) begin
            push_pair(16'(16'h5000 + i), 16'(16'h6000 + i));
        end
        check_eq("t5_level8", 32'(level), 32'd8);
        fall_to_adv();
        flush   = 1'b1;
        s_valid = 1'b1;  // must be dropped
        #1;
        check_eq("t5_ready_flush", 32'(s_ready), 32'd0);
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        check_eq("t5_level", 32'(level), 32'd0);
        check_eq("t5_underrun", 32'(underrun), 32'd1);
        check_eq("t5_tx_l", 32'(tx_data_l), 32'd0);
        check_eq("t5_tx_r", 32'(tx_data_r), 32'd0);
        push_pair(16'hAAAA, 16'h5555);
        check_eq("t5_push_level", 32'(level), 32'd1);
        fall_to_adv();
        tick();
        check_eq("t5_after_l", 32'(tx_data_l), 32'hAAAA);
        check_eq("t5_after_r", 32'(tx_data_r), 32'h5555);

        // 6. Asynchronous reset mid-frame.
        push_pair(16'h1234, 16'h4321);
        for (int i = 0; i < 4; i++) begin
            push_pair(16'(16'h7000 + i), 16'(16'h8000 + i));
        end
        fall_to_adv();
        tick();
        check_eq("t6_pre_tx_l", 32'(tx_data_l), 32'h1234);
        check_eq("t6_pre_level", 32'(level), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_tx_l", 32'(tx_data_l), 32'd0);
        check_eq("t6_level", 32'(level), 32'd0);
        check_eq("t6_ready", 32'(s_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("t6_after_level", 32'(level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
